// File: rtl/writeback_arbiter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Collects writeback offers from three execution units (index 0 = FX,
// 1 = LdSt, 2 = Branch). Each unit owns a one-entry holding buffer. Every
// cycle at most one held entry is granted, and its bundle is registered onto
// the register-unit writeback outputs at the next rising edge.
//
// Configuration macro:
//   WB_ROUND_ROBIN_EN  defined   -> round-robin arbitration; the search starts
//                                   one past the last granted unit.
//                      undefined -> fixed priority LdSt > FX > Branch.
//
// Ports:
//   clock_i, reset_i                      clock, synchronous active-high reset
//   reqValid_i / reqReady_o [2:0]         per-unit offer handshake
//   reqReg{1,2}Data_i   [3*addressSize]   data, slice k belongs to unit k
//   reqReg{1,2}Addr_i   [3*regWidth]      register addresses, packed per unit
//   reqReg{1,2}Wb_i, reqIs64Bit_i [2:0]   write flags and mode bit per unit
//   wbValid_o                             writeback bundle valid this cycle
//   regWritebackFunctionalUnitCode_o      unit code of the granted unit
//   reg{1,2}WritebackData_o/Address_o     granted data and addresses
//   reg{1,2}isWriteback_o                 write strobes (flag AND wbValid_o)
//   is64Bit_o                             mode bit of the granted unit
//   grantCount_o [15:0]                   wrapping count of grants
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int         addressSize    = 64,
    parameter int         regWidth       = 5,
    parameter logic [2:0] FXUnitCode     = 3'd0,
    parameter logic [2:0] LdStUnitCode   = 3'd2,
    parameter logic [2:0] BranchUnitCode = 3'd3
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [2:0]                 reqValid_i,
    output logic [2:0]                 reqReady_o,
    input  logic [3*addressSize-1:0]   reqReg1Data_i,
    input  logic [3*addressSize-1:0]   reqReg2Data_i,
    input  logic [3*regWidth-1:0]      reqReg1Addr_i,
    input  logic [3*regWidth-1:0]      reqReg2Addr_i,
    input  logic [2:0]                 reqReg1Wb_i,
    input  logic [2:0]                 reqReg2Wb_i,
    input  logic [2:0]                 reqIs64Bit_i,
    output logic                       wbValid_o,
    output logic [2:0]                 regWritebackFunctionalUnitCode_o,
    output logic [addressSize-1:0]     reg1WritebackData_o,
    output logic [addressSize-1:0]     reg2WritebackData_o,
    output logic [regWidth-1:0]        reg1WritebackAddress_o,
    output logic [regWidth-1:0]        reg2WritebackAddress_o,
    output logic                       reg1isWriteback_o,
    output logic                       reg2isWriteback_o,
    output logic                       is64Bit_o,
    output logic [15:0]                grantCount_o
);

    localparam int NumReq = 3;

    typedef struct packed {
        logic [addressSize-1:0] reg1_data;
        logic [addressSize-1:0] reg2_data;
        logic [regWidth-1:0]    reg1_addr;
        logic [regWidth-1:0]    reg2_addr;
        logic                   reg1_wb;
        logic                   reg2_wb;
        logic                   is64;
    } wb_entry_t;

    wb_entry_t [NumReq-1:0] entry_q, entry_d;
    logic [NumReq-1:0]      held_q, held_d;
    logic [NumReq-1:0]      grant;
    logic [NumReq-1:0]      xfer;

    wb_entry_t  sel_entry;
    logic [2:0] sel_code;

    logic                   wb_valid_q, wb_valid_d;
    logic [2:0]             unit_code_q, unit_code_d;
    wb_entry_t              out_entry_q, out_entry_d;
    logic [15:0]            grant_count_q, grant_count_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef WB_ROUND_ROBIN_EN
    // rr_ptr_q is the first unit searched this cycle: one past the last grant.
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       found;

    function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] offset);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && held_q[rr_index(rr_ptr_q, 2'(i))]) begin
                grant[rr_index(rr_ptr_q, 2'(i))] = 1'b1;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant[0]) begin
            rr_ptr_d = 2'd1;
        end else if (grant[1]) begin
            rr_ptr_d = 2'd2;
        end else if (grant[2]) begin
            rr_ptr_d = 2'd0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority LdSt > FX > Branch; a busy LdSt may starve the others.
    always_comb begin
        grant = '0;
        if (held_q[1]) begin
            grant[1] = 1'b1;
        end else if (held_q[0]) begin
            grant[0] = 1'b1;
        end else if (held_q[2]) begin
            grant[2] = 1'b1;
        end
    end
`endif

    // A granted buffer drains at this edge, so it can take a new offer in the
    // same edge; this gives back-to-back throughput per unit.
    assign reqReady_o = reset_i ? '0 : (~held_q | grant);
    assign xfer       = reqValid_i & reqReady_o;

    // -------------------------------------------------------------------------
    // Holding buffers
    // -------------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            entry_d[k] = entry_q[k];
            held_d[k]  = held_q[k] & ~grant[k];
            if (xfer[k]) begin
                entry_d[k].reg1_data = reqReg1Data_i[k*addressSize +: addressSize];
                entry_d[k].reg2_data = reqReg2Data_i[k*addressSize +: addressSize];
                entry_d[k].reg1_addr = reqReg1Addr_i[k*regWidth +: regWidth];
                entry_d[k].reg2_addr = reqReg2Addr_i[k*regWidth +: regWidth];
                entry_d[k].reg1_wb   = reqReg1Wb_i[k];
                entry_d[k].reg2_wb   = reqReg2Wb_i[k];
                entry_d[k].is64      = reqIs64Bit_i[k];
                held_d[k]            = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output bundle selection
    // -------------------------------------------------------------------------
    always_comb begin
        sel_entry = '0;
        sel_code  = FXUnitCode;
        if (grant[1]) begin
            sel_entry = entry_q[1];
            sel_code  = LdStUnitCode;
        end else if (grant[2]) begin
            sel_entry = entry_q[2];
            sel_code  = BranchUnitCode;
        end else if (grant[0]) begin
            sel_entry = entry_q[0];
            sel_code  = FXUnitCode;
        end
    end

    // Data, address, code and mode hold their last values when idle.
    always_comb begin
        wb_valid_d    = |grant;
        unit_code_d   = unit_code_q;
        out_entry_d   = out_entry_q;
        grant_count_d = grant_count_q;
        if (|grant) begin
            unit_code_d   = sel_code;
            out_entry_d   = sel_entry;
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            held_q        <= '0;
            wb_valid_q    <= 1'b0;
            unit_code_q   <= 3'd0;
            out_entry_q   <= '0;
            grant_count_q <= 16'd0;
        end else begin
            held_q        <= held_d;
            wb_valid_q    <= wb_valid_d;
            unit_code_q   <= unit_code_d;
            out_entry_q   <= out_entry_d;
            grant_count_q <= grant_count_d;
        end
    end

    // NOTE: buffer payloads are not reset; held_q alone says whether an entry
    // is live, so clearing it is enough to drop buffered writes.
    always_ff @(posedge clock_i) begin
        entry_q <= entry_d;
    end

    assign wbValid_o                        = wb_valid_q;
    assign regWritebackFunctionalUnitCode_o = unit_code_q;
    assign reg1WritebackData_o              = out_entry_q.reg1_data;
    assign reg2WritebackData_o              = out_entry_q.reg2_data;
    assign reg1WritebackAddress_o           = out_entry_q.reg1_addr;
    assign reg2WritebackAddress_o           = out_entry_q.reg2_addr;
    assign reg1isWriteback_o                = out_entry_q.reg1_wb & wb_valid_q;
    assign reg2isWriteback_o                = out_entry_q.reg2_wb & wb_valid_q;
    assign is64Bit_o                        = out_entry_q.is64;
    assign grantCount_o                     = grant_count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed stimulus for writeback_arbiter with a transaction-level model of
// the holding buffers and arbitration policy (round-robin when
// WB_ROUND_ROBIN_EN is defined, fixed LdSt > FX > Branch otherwise). A compare
// process checks every output against the model on each falling edge; the
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int AW = 64;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        valid;
    logic [2:0]        ready;
    logic [3*AW-1:0]   r1d, r2d;
    logic [3*RW-1:0]   r1a, r2a;
    logic [2:0]        w1, w2, m64;
    logic              wb_valid;
    logic [2:0]        code;
    logic [AW-1:0]     o_d1, o_d2;
    logic [RW-1:0]     o_a1, o_a2;
    logic              o_w1, o_w2, o_m;
    logic [15:0]       cnt;

    int checks = 0;
    int errors = 0;

    writeback_arbiter dut (
        .clock_i                          (clk),
        .reset_i                          (rst),
        .reqValid_i                       (valid),
        .reqReady_o                       (ready),
        .reqReg1Data_i                    (r1d),
        .reqReg2Data_i                    (r2d),
        .reqReg1Addr_i                    (r1a),
        .reqReg2Addr_i                    (r2a),
        .reqReg1Wb_i                      (w1),
        .reqReg2Wb_i                      (w2),
        .reqIs64Bit_i                     (m64),
        .wbValid_o                        (wb_valid),
        .regWritebackFunctionalUnitCode_o (code),
        .reg1WritebackData_o              (o_d1),
        .reg2WritebackData_o              (o_d2),
        .reg1WritebackAddress_o           (o_a1),
        .reg2WritebackAddress_o           (o_a2),
        .reg1isWriteback_o                (o_w1),
        .reg2isWriteback_o                (o_w2),
        .is64Bit_o                        (o_m),
        .grantCount_o                     (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Model: one pending slot per unit, a policy that names the next winner,
    // and the last bundle handed to the register unit.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [AW-1:0] d1;
        logic [AW-1:0] d2;
        logic [RW-1:0] a1;
        logic [RW-1:0] a2;
        logic          w1;
        logic          w2;
        logic          m;
    } ent_t;

    ent_t        m_buf [3];
    bit          m_held [3];
    int          m_start;
    bit          model_on = 1'b0;
    logic        e_valid;
    logic [2:0]  e_code;
    ent_t        e_out;
    logic [15:0] e_cnt;

    function automatic logic [2:0] code_of(input int k);
        case (k)
            0:       return 3'd0;
            1:       return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    function automatic int pick();
`ifdef WB_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++) begin
            if (m_held[(m_start + i) % 3]) return (m_start + i) % 3;
        end
`else
        if (m_held[1]) return 1;
        if (m_held[0]) return 0;
        if (m_held[2]) return 2;
`endif
        return -1;
    endfunction

    function automatic logic model_ready(input int k);
        if (rst) return 1'b0;
        return !m_held[k] || (pick() == k);
    endfunction

    always @(posedge clk) begin : model
        bit acc [3];
        int g;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_held[k] = 1'b0;
            m_start  = 0;
            e_valid  = 1'b0;
            e_code   = 3'd0;
            e_out    = '0;
            e_cnt    = 16'd0;
            model_on = 1'b1;
        end else if (model_on) begin
            for (int k = 0; k < 3; k++) acc[k] = valid[k] && model_ready(k);
            g = pick();
            e_valid = (g >= 0);
            if (g >= 0) begin
                e_out     = m_buf[g];
                e_code    = code_of(g);
                e_cnt     = e_cnt + 16'd1;
                m_held[g] = 1'b0;
                m_start   = (g + 1) % 3;
            end
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) begin
                    m_buf[k] = '{d1: r1d[k*AW +: AW], d2: r2d[k*AW +: AW],
                                 a1: r1a[k*RW +: RW], a2: r2a[k*RW +: RW],
                                 w1: w1[k], w2: w2[k], m: m64[k]};
                    m_held[k] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (model_on) begin
            check("wbValid",    wb_valid, e_valid);
            check("unitCode",   code,     e_code);
            check("reg1Data",   o_d1,     e_out.d1);
            check("reg2Data",   o_d2,     e_out.d2);
            check("reg1Addr",   o_a1,     e_out.a1);
            check("reg2Addr",   o_a2,     e_out.a2);
            check("reg1Strobe", o_w1,     e_valid & e_out.w1);
            check("reg2Strobe", o_w2,     e_valid & e_out.w2);
            check("is64Bit",    o_m,      e_out.m);
            check("grantCount", cnt,      e_cnt);
            for (int k = 0; k < 3; k++) check("reqReady", ready[k], model_ready(k));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge.
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int k, input logic [AW-1:0] d1, input logic [AW-1:0] d2,
                         input logic [RW-1:0] a1, input logic [RW-1:0] a2,
                         input logic f1, input logic f2, input logic md);
        valid[k]          = 1'b1;
        r1d[k*AW +: AW]   = d1;
        r2d[k*AW +: AW]   = d2;
        r1a[k*RW +: RW]   = a1;
        r2a[k*RW +: RW]   = a2;
        w1[k]             = f1;
        w2[k]             = f2;
        m64[k]            = md;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] ord [3];
        rst = 1'b1; valid = '0;
        r1d = '0; r2d = '0; r1a = '0; r2a = '0; w1 = '0; w2 = '0; m64 = '0;

        // Reset state
        do_reset();
        check("rst_wbValid", wb_valid, 1'b0);
        check("rst_count",   cnt,      16'd0);
        check("rst_data",    o_d1,     64'd0);
        check("rst_code",    code,     3'd0);
        check("rst_ready",   ready,    3'b111);

        // Single FX writeback from idle
        offer(0, 64'h1234, 64'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        valid = '0;
        tick();
        check("fx_valid",   wb_valid, 1'b1);
        check("fx_code",    code,     3'd0);
        check("fx_addr",    o_a1,     5'd5);
        check("fx_data",    o_d1,     64'h1234);
        check("fx_strobe1", o_w1,     1'b1);
        check("fx_strobe2", o_w2,     1'b0);
        check("fx_count",   cnt,      16'd1);
        tick();
        check("idle_valid",  wb_valid, 1'b0);
        check("idle_hold",   o_d1,     64'h1234);
        check("idle_strobe", o_w1,     1'b0);

        // All three units offer at the same edge
        do_reset();
        offer(0, 64'hA0, 64'h0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        offer(1, 64'hA1, 64'h0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        offer(2, 64'hA2, 64'h0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        valid = '0;
        #1;
`ifdef WB_ROUND_ROBIN_EN
        check("all3_ready", ready, 3'b001);
        ord[0] = 3'd0; ord[1] = 3'd2; ord[2] = 3'd3;
`else
        check("all3_ready", ready, 3'b010);
        ord[0] = 3'd2; ord[1] = 3'd0; ord[2] = 3'd3;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("all3_valid", wb_valid, 1'b1);
            check("all3_code",  code,     ord[i]);
        end
        check("all3_ready_after", ready, 3'b111);
        check("all3_count",       cnt,   16'd3);

        // LdSt and FX continuously valid
        do_reset();
        offer(0, 64'hF0, 64'h0, 5'd9,  5'd0, 1'b1, 1'b0, 1'b1);
        offer(1, 64'hF1, 64'h0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("contend_valid", wb_valid, 1'b1);
`ifdef WB_ROUND_ROBIN_EN
            check("contend_code", code, (i % 2 == 0) ? 3'd0 : 3'd2);
`else
            check("contend_code",    code,     3'd2);
            check("contend_fxready", ready[0], 1'b0);
`endif
        end
        valid = '0;

        // LdSt alone, back-to-back with fresh data each cycle
        do_reset();
        for (int j = 0; j < 8; j++) begin
            offer(1, 64'd100 + 64'(j), 64'd200 + 64'(j), 5'd3, 5'd4, 1'b1, 1'b1, 1'b1);
            tick();
            if (j > 0) begin
                check("b2b_valid",  wb_valid, 1'b1);
                check("b2b_code",   code,     3'd2);
                check("b2b_addr1",  o_a1,     5'd3);
                check("b2b_addr2",  o_a2,     5'd4);
                check("b2b_strb1",  o_w1,     1'b1);
                check("b2b_strb2",  o_w2,     1'b1);
                check("b2b_data1",  o_d1,     64'd99 + 64'(j));
                check("b2b_data2",  o_d2,     64'd199 + 64'(j));
                check("b2b_ready",  ready[1], 1'b1);
            end
        end
        valid = '0;
        tick();
        check("b2b_last_data", o_d1, 64'd107);
        check("b2b_count",     cnt,  16'd8);

        // Reset while FX and Branch are held
        do_reset();
        offer(0, 64'hC0, 64'h0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        offer(2, 64'hC2, 64'h0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        valid = '0;
        rst   = 1'b1;
        #1;
        check("midrst_ready", ready, 3'b000);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", wb_valid, 1'b0);
        check("midrst_count", cnt,      16'd0);
        check("midrst_data",  o_d1,     64'd0);
        check("midrst_held",  ready,    3'b111);
        tick();
        check("midrst_nostale", wb_valid, 1'b0);
        offer(0, 64'hBEEF, 64'h0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        valid = '0;
        tick();
        check("postrst_valid", wb_valid, 1'b1);
        check("postrst_code",  code,     3'd0);
        check("postrst_addr",  o_a1,     5'd7);
        check("postrst_data",  o_d1,     64'hBEEF);
        check("postrst_count", cnt,      16'd1);

        // Grant counter wrap
        do_reset();
        offer(1, 64'h5, 64'h0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        repeat (65535) tick();
        check("wrap_full",  cnt,      16'hFFFF);
        tick();
        check("wrap_zero",  cnt,      16'd0);
        check("wrap_valid", wb_valid, 1'b1);
        valid = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
